spi_slave: RTL and testbench

SPI responder (slave) for the SPI-DSD design, the far end of the team's SPI master link. It runs entirely on the system clock: it oversamples and synchronises the external SCLK/CS_N/MOSI pins, deserialises MOSI into parallel words, and serialises a host-supplied word onto MISO. The block supports mode 0 only (CPOL=0, CPHA=0), MSB first, with back-to-back multi-word transfers inside one CS_N assertion.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 43 ++++
 rtl/spi_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI-DSD link blocks (spi_slave, spi_master).
//   spi_state_e  : responder FSM state encoding (IDLE, ACTIVE)
//   SPI_DATA_W   : default word width in bits
//   SPI_CPOL/SPI_CPHA/SPI_MSB_FIRST : the only supported mode (mode 0, MSB first)
//   SPI_SYNC_STAGES : metastability flops in front of every pin
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_W      = 8;
  localparam bit SPI_CPOL        = 1'b0;
  localparam bit SPI_CPHA        = 1'b0;
  localparam bit SPI_MSB_FIRST   = 1'b1;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchroniser for one asynchronous pin, followed by a
// previous-value register and registered edge strobes.
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : asynchronous input
//   level      : synchronised level, aligned with the strobes (same stage)
//   rise, fall : one-cycle strobes, 3 clk after the pin edge
// RST_VAL is the idle level of the pin, so leaving reset creates no strobe.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      prev <= s2;
      // Strobes are registered in the same stage as prev, so level and the
      // strobes describe the same pin sample.
      rise <= s2 & ~prev;
      fall <= ~s2 & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder running on the system clock.
//   clk, rst_n        : system clock (>= 8x SCLK), asynchronous active-low reset
//   sclk, cs_n, mosi  : asynchronous SPI pins
//   miso, miso_oe     : serial data out and its tri-state enable
//   tx_data/tx_valid/tx_ready : host word into a one-deep holding register
//   rx_data/rx_valid  : last completed word and its one-cycle pulse
//   tx_underrun       : pulse when IDLE_WORD is sent in place of a host word
//   busy              : FSM is ACTIVE (doubles as the state observation point)
//
// Host handshake: a word transfers on a clk edge where tx_valid && tx_ready;
// tx_valid may be raised at any time and tx_data must be stable while it is
// high; tx_ready does not depend on tx_valid.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                 DATA_W    = SPI_DATA_W,
  parameter logic [DATA_W-1:0]  IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int               CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  // Synchronised pins
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  // FSM and datapath state
  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] shift_in_next;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic              started;   // at least one bit received since CS_N fell

  // Control decoded by the FSM
  logic load;          // fill shift_out from holding register or IDLE_WORD
  logic start;         // new CS_N assertion: restart bit counting
  logic sample;        // capture one MOSI bit
  logic shift_out_en;  // advance MISO to the next bit

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    start        = 1'b0;
    sample       = 1'b0;
    shift_out_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        // CS_N release wins over any SCLK strobe in the same cycle, so a
        // final SCLK fall that coincides with it does not consume a tx word.
        if (cs_rise) begin
          state_d = IDLE;
        end else begin
          if (sclk_rise) sample = 1'b1;
          if (sclk_fall) begin
            // bit_cnt wrapped to 0 means the previous word just completed;
            // before the first rise there is nothing to advance past.
            if (bit_cnt == '0 && started) load = 1'b1;
            else                          shift_out_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_in_next = {shift_in[DATA_W-2:0], mosi_lvl};

  // Receive path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_in <= '0;
      bit_cnt  <= '0;
      started  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start) begin
        bit_cnt <= '0;
        started <= 1'b0;
      end else if (sample) begin
        shift_in <= shift_in_next;
        started  <= 1'b1;
        if (bit_cnt == LAST) begin
          bit_cnt  <= '0;
          rx_data  <= shift_in_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Transmit path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_out   <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load) begin
        shift_out   <= hold_full ? hold_data : IDLE_WORD;
        tx_underrun <= ~hold_full;
      end else if (shift_out_en) begin
        shift_out <= {shift_out[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Holding register. A host write is only accepted while empty, so a
  // same-cycle load necessarily found it empty and the write simply lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy & ~cs_lvl;
  assign miso     = miso_oe & shift_out[DATA_W-1];

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         under_cnt;

  spi_slave #(.DATA_W(8), .IDLE_WORD(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed traffic
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) under_cnt = under_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Driver tasks
  task automatic host_write(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("host_ready_timeout", 32'd1, 32'd0);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_start();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  // One mode-0 bit: 8 clk low (MOSI set midway, MISO sampled at the end), 8 clk high.
  task automatic spi_bit(input logic b, input logic end_cs, output logic m);
    repeat (4) @(negedge clk);
    mosi = b;
    repeat (4) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    if (end_cs) cs_n = 1'b1;
  endtask

  task automatic spi_word(input logic [7:0] w, input logic end_cs, output logic [7:0] got);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(w[i], end_cs && (i == 0), m);
      got[i] = m;
    end
  endtask

  task automatic pop_rx(input string name, input logic [7:0] exp);
    if (rx_q.size() == 0) begin
      chk({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      chk(name, 32'(rx_q.pop_front()), 32'(exp));
    end
  endtask

  typedef struct {
    logic       preload;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_under;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] got0, got1;
    logic [7:0] rx_before;
    logic       m;
    bit         bad_oe;

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; under_cnt = 0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h96, 8'h00, 8'h96, 1};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 0};

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-word table
    for (int v = 0; v < 4; v++) begin
      under_cnt = 0;
      rx_q.delete();
      if (vecs[v].preload) host_write(vecs[v].tx);
      spi_start();
      spi_word(vecs[v].mosi_w, 1'b1, got0);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_miso", v), 32'(got0), 32'(vecs[v].exp_miso));
      chk($sformatf("v%0d_rx_count", v), 32'(rx_q.size()), 32'd1);
      pop_rx($sformatf("v%0d_rx", v), vecs[v].exp_rx);
      chk($sformatf("v%0d_underrun", v), 32'(under_cnt), 32'(vecs[v].exp_under));
      chk($sformatf("v%0d_tx_ready", v), 32'(tx_ready), 32'd1);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
    end

    // Back-to-back words, second host word written while the first shifts
    under_cnt = 0;
    rx_q.delete();
    host_write(8'h11);
    fork
      begin
        spi_start();
        spi_word(8'hF0, 1'b0, got0);
        spi_word(8'h0F, 1'b1, got1);
      end
      host_write(8'h22);
    join
    repeat (8) @(negedge clk);
    chk("b2b_miso0", 32'(got0), 32'h11);
    chk("b2b_miso1", 32'(got1), 32'h22);
    chk("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    pop_rx("b2b_rx0", 8'hF0);
    pop_rx("b2b_rx1", 8'h0F);
    chk("b2b_underrun", 32'(under_cnt), 32'd0);
    chk("b2b_tx_ready", 32'(tx_ready), 32'd1);

    // Underrun on both words
    under_cnt = 0;
    rx_q.delete();
    spi_start();
    spi_word(8'hA3, 1'b0, got0);
    spi_word(8'h5C, 1'b1, got1);
    repeat (8) @(negedge clk);
    chk("und_miso0", 32'(got0), 32'h00);
    chk("und_miso1", 32'(got1), 32'h00);
    chk("und_count", 32'(under_cnt), 32'd2);
    pop_rx("und_rx0", 8'hA3);
    pop_rx("und_rx1", 8'h5C);

    // Abort after 5 bits
    rx_q.delete();
    rx_before = rx_data;
    spi_start();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, m);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy_3clk", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_busy_4clk", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_rx", 32'(rx_q.size()), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'(rx_before));
    spi_start();
    spi_word(8'h81, 1'b1, got0);
    repeat (8) @(negedge clk);
    pop_rx("abort_next_rx", 8'h81);

    // Reset during bit 3
    rx_q.delete();
    host_write(8'h77);
    spi_start();
    spi_bit(1'b0, 1'b0, m);
    spi_bit(1'b1, 1'b0, m);
    repeat (4) @(negedge clk);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    chk("midword_busy", 32'(busy), 32'd1);
    chk("midword_oe", 32'(miso_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_q.delete();
    under_cnt = 0;
    host_write(8'hC3);
    spi_start();
    spi_word(8'h5A, 1'b1, got0);
    repeat (8) @(negedge clk);
    chk("post_rst_miso", 32'(got0), 32'hC3);
    pop_rx("post_rst_rx", 8'h5A);
    chk("post_rst_underrun", 32'(under_cnt), 32'd0);

    // SCLK toggling with CS_N high
    rx_q.delete();
    rx_before = rx_data;
    bad_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = ~sclk;
      repeat (4) @(negedge clk);
      if (miso_oe !== 1'b0 || miso !== 1'b0 || busy !== 1'b0) bad_oe = 1'b1;
    end
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_oe_low", 32'(bad_oe), 32'd0);
    chk("idle_no_rx", 32'(rx_q.size()), 32'd0);
    chk("idle_rx_data", 32'(rx_data), 32'(rx_before));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
